// File: rtl/vga_pattern_core.sv
// vga_pattern_core
//   Test-pattern generator and blender for a pixel stream.
//   A small register slot selects bars, checker, gradient or solid patterns.
//   The pattern is optionally averaged with the upstream pixel.
//   so_rgb is registered, one clock after x/y/si_rgb.
//   Pattern settings and scroll advance once per frame, on the frame-start pulse.
//
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   x, y     in   current pixel coordinates (XW bits)
//   cs       in   slot chip select
//   write    in   slot write strobe (write when cs & write)
//   addr     in   slot word address, addr[1:0] decoded
//   wr_data  in   slot write data
//   si_rgb   in   upstream pixel {R,G,B}
//   so_rgb   out  downstream pixel {R,G,B}, registered
module vga_pattern_core #(
  parameter int unsigned CD = 4,
  parameter int unsigned XW = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [XW-1:0]     x,
  input  logic [XW-1:0]     y,
  input  logic              cs,
  input  logic              write,
  input  logic [13:0]       addr,
  input  logic [31:0]       wr_data,
  input  logic [3*CD-1:0]   si_rgb,
  output logic [3*CD-1:0]   so_rgb
);

  localparam int unsigned RW = 3 * CD;

  // Active registers
  logic          r_bypass;
  logic [1:0]    r_mode;
  logic          r_blend;
  logic [RW-1:0] r_color0;
  logic [RW-1:0] r_color1;
  logic [3:0]    r_shift;
  logic [7:0]    r_speed;

  // Per-frame shadow copies used by the pattern datapath
  logic [1:0]    r_sh_mode;
  logic          r_sh_blend;
  logic [RW-1:0] r_sh_color0;
  logic [RW-1:0] r_sh_color1;
  logic [3:0]    r_sh_shift;

  logic [XW-1:0] r_scroll;
  logic          r_origin;
  logic [RW-1:0] r_so;

  logic          w_we;
  logic          w_origin;
  logic          w_fs;
  logic [XW-1:0] w_xe;
  logic          w_shift_big;
  logic [XW-1:0] w_xs;
  logic [XW-1:0] w_ys;
  logic [2:0]    w_k;
  logic          w_chk;
  logic [CD-1:0] w_g;
  logic [RW-1:0] w_pat;
  logic [RW-1:0] w_mix;
  logic [RW-1:0] w_pix;
  logic          w_unused;

  assign w_we     = cs & write;
  assign w_origin = (x == '0) && (y == '0);
  // Pulse only on the first cycle of the origin, not for as long as it is held
  assign w_fs     = w_origin & ~r_origin;

  // Register slot; writes land on the active set regardless of frame timing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bypass <= 1'b1;
      r_mode   <= 2'd0;
      r_blend  <= 1'b0;
      r_color0 <= '1;
      r_color1 <= '0;
      r_shift  <= 4'd4;
      r_speed  <= 8'd0;
    end else if (w_we) begin
      case (addr[1:0])
        2'd0: begin
          r_bypass <= wr_data[0];
          r_mode   <= wr_data[2:1];
          r_blend  <= wr_data[3];
        end
        2'd1: r_color0 <= wr_data[RW-1:0];
        2'd2: r_color1 <= wr_data[RW-1:0];
        default: begin
          r_shift <= wr_data[3:0];
          r_speed <= wr_data[15:8];
        end
      endcase
    end
  end

  // Shadows and scroll sample the pre-write register values on frame start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_origin    <= 1'b0;
      r_sh_mode   <= 2'd0;
      r_sh_blend  <= 1'b0;
      r_sh_color0 <= '1;
      r_sh_color1 <= '0;
      r_sh_shift  <= 4'd4;
      r_scroll    <= '0;
    end else begin
      r_origin <= w_origin;
      if (w_fs) begin
        r_sh_mode   <= r_mode;
        r_sh_blend  <= r_blend;
        r_sh_color0 <= r_color0;
        r_sh_color1 <= r_color1;
        r_sh_shift  <= r_shift;
        r_scroll    <= r_scroll + XW'(r_speed);
      end
    end
  end

  assign w_xe        = x + r_scroll;
  // Shifting the whole counter away collapses the frame onto index 0
  assign w_shift_big = ({28'd0, r_sh_shift} >= 32'(XW));
  assign w_xs        = w_shift_big ? '0 : (w_xe >> r_sh_shift);
  assign w_ys        = w_shift_big ? '0 : (y >> r_sh_shift);
  assign w_k         = w_xs[2:0];
  assign w_chk       = w_xs[0] ^ w_ys[0];
  assign w_g         = w_xs[CD-1:0];

  always_comb begin
    w_pat = '0;
    case (r_sh_mode)
      2'd0:    w_pat = {{CD{w_k[2]}}, {CD{w_k[1]}}, {CD{w_k[0]}}};
      2'd1:    w_pat = w_chk ? r_sh_color1 : r_sh_color0;
      2'd2:    w_pat = {w_g, w_g, w_g} & r_sh_color0;
      default: w_pat = r_sh_color0;
    endcase
  end

  // Per-channel floor average at CD+1 bits
  for (genvar c = 0; c < 3; c++) begin : g_blend
    logic [CD:0] w_sum;
    assign w_sum                = {1'b0, si_rgb[c*CD +: CD]} + {1'b0, w_pat[c*CD +: CD]};
    assign w_mix[c*CD +: CD]    = w_sum[CD:1];
  end

  assign w_pix = r_sh_blend ? w_mix : w_pat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_so <= '0;
    end else begin
      r_so <= r_bypass ? si_rgb : w_pix;
    end
  end

  assign so_rgb = r_so;

  assign w_unused = ^{addr[13:2], wr_data, w_xs, w_ys};

endmodule

// File: tb/tb_vga_pattern_core.sv
// Directed bench for vga_pattern_core (CD=4, XW=11).
// Inputs change 1 time unit after the rising edge; so_rgb is checked at the same point
// after the following edge, i.e. exactly one clock of latency.
module tb_vga_pattern_core;

  localparam int unsigned CD = 4;
  localparam int unsigned XW = 11;
  localparam int unsigned RW = 3 * CD;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [XW-1:0] x;
  logic [XW-1:0] y;
  logic          cs;
  logic          write;
  logic [13:0]   addr;
  logic [31:0]   wr_data;
  logic [RW-1:0] si_rgb;
  logic [RW-1:0] so_rgb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vga_pattern_core #(
    .CD(CD),
    .XW(XW)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (x),
    .y       (y),
    .cs      (cs),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .si_rgb  (si_rgb),
    .so_rgb  (so_rgb)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cs      = 1'b1;
    write   = 1'b1;
    addr    = {12'd0, a};
    wr_data = d;
    tick();
    cs    = 1'b0;
    write = 1'b0;
  endtask

  task automatic px(input logic [XW-1:0] xv, input logic [XW-1:0] yv, input logic [RW-1:0] s);
    x      = xv;
    y      = yv;
    si_rgb = s;
    tick();
  endtask

  // One cycle at the origin then leave it, so history is clear for the next one
  task automatic do_fs();
    x = '0;
    y = '0;
    tick();
    x = 11'd1;
    y = 11'd1;
    tick();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    x       = 11'd1;
    y       = 11'd1;
    cs      = 1'b0;
    write   = 1'b0;
    addr    = '0;
    wr_data = '0;
    si_rgb  = 12'h000;

    tick();
    tick();
    check_eq("reset_so", so_rgb, 32'h000);
    reset_n = 1'b1;

    // Bypass is the reset default
    px(11'd5, 11'd0, 12'hABC);
    check_eq("bypass_default", so_rgb, 32'hABC);

    // Bars, shift 4
    wr(2'd0, 32'h0);
    wr(2'd3, 32'h4);
    do_fs();
    px(11'h25, 11'd1, 12'h000);
    check_eq("bars_k2", so_rgb, 32'h0F0);
    px(11'h70, 11'd1, 12'h000);
    check_eq("bars_k7", so_rgb, 32'hFFF);
    px(11'h10, 11'd1, 12'h000);
    check_eq("bars_k1", so_rgb, 32'h00F);

    // Bypass is not shadowed
    wr(2'd0, 32'h1);
    px(11'd1, 11'd1, 12'h5A5);
    check_eq("bypass_on_now", so_rgb, 32'h5A5);
    wr(2'd0, 32'h0);
    px(11'h25, 11'd1, 12'h5A5);
    check_eq("bypass_off_now", so_rgb, 32'h0F0);

    // Checker, settings deferred until frame start
    wr(2'd0, 32'h2);
    wr(2'd3, 32'h3);
    wr(2'd1, 32'h123);
    wr(2'd2, 32'h456);
    px(11'h25, 11'd1, 12'h000);
    check_eq("deferred_mode", so_rgb, 32'h0F0);
    do_fs();
    px(11'd8, 11'd0, 12'h000);
    check_eq("checker_c1", so_rgb, 32'h456);
    px(11'd8, 11'd8, 12'h000);
    check_eq("checker_c0", so_rgb, 32'h123);

    // Gradient, shift 0, masked by color0
    wr(2'd0, 32'h4);
    wr(2'd3, 32'h0);
    wr(2'd1, 32'hF0F);
    do_fs();
    px(11'h1A, 11'd1, 12'h000);
    check_eq("grad_a", so_rgb, 32'hA0A);
    px(11'h7F5, 11'd1, 12'h000);
    check_eq("grad_5", so_rgb, 32'h505);

    // Shift boundary: 10 still indexes, 11 collapses to bar 0
    wr(2'd0, 32'h0);
    wr(2'd3, 32'd10);
    do_fs();
    px(11'h7FF, 11'd5, 12'h000);
    check_eq("shift10", so_rgb, 32'h00F);
    wr(2'd3, 32'd11);
    do_fs();
    px(11'h7FF, 11'd5, 12'h000);
    check_eq("shift11", so_rgb, 32'h000);

    // Solid + blend
    wr(2'd0, 32'hE);
    wr(2'd1, 32'hF00);
    do_fs();
    px(11'd3, 11'd1, 12'h0F1);
    check_eq("blend_770", so_rgb, 32'h770);
    px(11'd3, 11'd1, 12'hFFF);
    check_eq("blend_f77", so_rgb, 32'hF77);
    wr(2'd0, 32'h0);
    wr(2'd3, 32'h4);
    px(11'd3, 11'd1, 12'h0F1);
    check_eq("blend_held", so_rgb, 32'h770);
    do_fs();
    px(11'h25, 11'd1, 12'h0F1);
    check_eq("blend_next_frame", so_rgb, 32'h0F0);

    // Scroll accumulation
    apply_reset();
    wr(2'd0, 32'h0);
    wr(2'd3, 32'h1004);
    do_fs();
    px(11'h05, 11'd1, 12'h000);
    check_eq("scroll_10", so_rgb, 32'h00F);
    do_fs();
    px(11'h05, 11'd1, 12'h000);
    check_eq("scroll_20", so_rgb, 32'h0F0);

    // Scroll wrap: 8 x 0xFF = 0x7F8, then + 0x10 = 0x008
    apply_reset();
    wr(2'd0, 32'h0);
    wr(2'd3, 32'hFF04);
    for (int i = 0; i < 8; i++) do_fs();
    px(11'h08, 11'd1, 12'h000);
    check_eq("scroll_7f8_a", so_rgb, 32'h000);
    px(11'h28, 11'd1, 12'h000);
    check_eq("scroll_7f8_b", so_rgb, 32'h0F0);
    wr(2'd3, 32'h1004);
    do_fs();
    px(11'h18, 11'd1, 12'h000);
    check_eq("scroll_wrap_a", so_rgb, 32'h0F0);
    px(11'h08, 11'd1, 12'h000);
    check_eq("scroll_wrap_b", so_rgb, 32'h00F);

    // Write coinciding with frame start
    apply_reset();
    wr(2'd0, 32'h0);
    wr(2'd3, 32'h4);
    do_fs();
    x       = '0;
    y       = '0;
    cs      = 1'b1;
    write   = 1'b1;
    addr    = 14'd0;
    wr_data = 32'h6;
    tick();
    cs    = 1'b0;
    write = 1'b0;
    x     = 11'd1;
    y     = 11'd1;
    tick();
    px(11'h25, 11'd1, 12'h000);
    check_eq("fs_write_old", so_rgb, 32'h0F0);
    do_fs();
    px(11'h25, 11'd1, 12'h000);
    check_eq("fs_write_new", so_rgb, 32'hFFF);

    // Holding the origin for a second cycle is not another frame start
    x = '0;
    y = '0;
    tick();
    cs      = 1'b1;
    write   = 1'b1;
    addr    = 14'd0;
    wr_data = 32'h0;
    tick();
    cs    = 1'b0;
    write = 1'b0;
    x     = 11'd1;
    y     = 11'd1;
    tick();
    px(11'h25, 11'd1, 12'h000);
    check_eq("fs_single_pulse", so_rgb, 32'hFFF);

    // Asynchronous reset mid-frame
    reset_n = 1'b0;
    #1;
    check_eq("async_reset_now", so_rgb, 32'h000);
    tick();
    check_eq("async_reset_hold", so_rgb, 32'h000);
    reset_n = 1'b1;
    px(11'd3, 11'd1, 12'h321);
    check_eq("bypass_restored", so_rgb, 32'h321);
    wr(2'd0, 32'h0);
    do_fs();
    px(11'h25, 11'd1, 12'h000);
    check_eq("post_reset_shadow", so_rgb, 32'h0F0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_pattern_core.md
VGA_PATTERN_CORE -- requirements
Module: vga_pattern_core

Interface
REQ-001 Parameter CD, default 4, colour depth in bits per channel; pixel width is RW = 3*CD, packed {R,G,B}.
REQ-002 Parameter XW, default 11, width of the x/y frame counters.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 x, y  input  XW  current pixel coordinates from the global frame counter.
REQ-006 cs  input  1  video slot chip select.
REQ-007 write  input  1  slot write strobe; a write occurs when cs & write.
REQ-008 addr  input  14  slot word address; only addr[1:0] is decoded.
REQ-009 wr_data  input  32  slot write data.
REQ-010 si_rgb  input  RW  upstream stream pixel.
REQ-011 so_rgb  output  RW  downstream stream pixel, registered.

Function
REQ-012 Register map: addr 0 = ctrl {bit0 bypass, bits[2:1] mode, bit3 blend}; addr 1 = color0[RW-1:0]; addr 2 = color1[RW-1:0]; addr 3 = {bits[3:0] shift, bits[15:8] speed}.
REQ-013 Register writes update the active register on the clock edge of the write; bits not listed are ignored.
REQ-014 Frame start (fs) is a one-cycle pulse, asserted on the first cycle in which (x==0 && y==0), detected against a registered copy of that condition.
REQ-015 On fs, mode, blend, color0, color1 and shift are copied into shadow registers; pattern generation uses only the shadow copies, so changes take effect at the next frame.
REQ-016 bypass is not shadowed and takes effect on the cycle after the write.
REQ-017 If a write and fs occur in the same cycle, the shadow captures the pre-write value and the active register takes the new value.
REQ-018 Scroll register, XW bits: on fs, scroll <= scroll + speed (zero-extended), modulo 2^XW.
REQ-019 xe = (x + scroll) mod 2^XW; the pattern uses xe and the raw y.
REQ-020 Mode 0 (bars): k = xe >> shift, bits [2:0]; the R, G and B channels are each all-ones when k[2], k[1] and k[0] respectively are 1, otherwise zero.
REQ-021 Mode 1 (checker): if bit 0 of ((xe>>shift) ^ (y>>shift)) is 0 the pattern is color0, otherwise color1.
REQ-022 Mode 2 (gradient): g = bits [CD-1:0] of (xe >> shift); the pattern is {g,g,g}, ANDed bitwise with color0.
REQ-023 Mode 3 (solid): the pattern is color0.
REQ-024 Blend: when blend is 1, each channel = (si_ch + pat_ch) >> 1, computed at CD+1 bits and truncated to CD bits (floor); when blend is 0, the output is the pattern.
REQ-025 so_rgb <= bypass ? si_rgb : blended_or_pattern, registered; the latency from x, y and si_rgb to so_rgb is exactly 1 clock.
REQ-026 A shift value >= XW yields an index of 0 (the whole frame is bar 0 or checker colour color0).

Reset
REQ-027 While reset_n = 0, the block holds these values: so_rgb = 0, bypass = 1, mode = 0, blend = 0, color0 = all-ones, color1 = 0, shift = 4, speed = 0, scroll = 0, shadows equal to these values, fs history = 0.
REQ-028 Reset asserted mid-frame clears the registers immediately and asynchronously; after release, the first fs loads the shadows from the reset-valued registers.

Verification
REQ-029 After reset, drive x=5, y=0, si_rgb=0xABC (CD=4) -> so_rgb=0xABC one cycle later (bypass default).
REQ-030 Write ctrl=0x0 and shift=4, then run to fs, then x=0x25 -> k=2 -> so_rgb=0x0F0; x=0x70 -> so_rgb=0xFFF.
REQ-031 Mode 1, shift=3, color0=0x123, color1=0x456, after fs: (x=8,y=0) -> 0x456; (x=8,y=8) -> 0x123.
REQ-032 Mode 3, blend=1, color0=0xF00, si_rgb=0x0F1 -> so_rgb=0x770; a mode write mid-frame leaves the output unchanged until the next fs.
REQ-033 speed=0x10, mode 0, shift=4: after 2 fs pulses scroll=0x20, and x=0x05 gives k=2 -> 0x0F0; check scroll wrap from 0x7F8 + 0x10 -> 0x008.
REQ-034 Write in the same cycle as fs -> the old value is used for that frame and the new value is used from the following fs; pulse reset_n low mid-frame -> so_rgb=0 immediately and bypass is restored.
